// File: rtl/ct_spsram_512x7_ctrl_pkg.sv
// Shared types and default geometry for the 512x7 single-port array controller.
package ct_spsram_512x7_ctrl_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } init_state_e;

  localparam int unsigned DEF_ADDR_W = 9;
  localparam int unsigned DEF_DATA_W = 7;

endpackage

// File: rtl/ct_spsram_init_seq.sv
// Clear sequencer: walks every array address once after reset or invalidate,
// then reports the array as ready for normal service.
module ct_spsram_init_seq
  import ct_spsram_512x7_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_W
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  inv_req_i,
  output logic                  init_busy_o,
  output logic                  init_done_o,
  output logic [ADDR_WIDTH-1:0] init_addr_o
);

  init_state_e           state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic                  done_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else if (inv_req_i) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else if (state_q == ST_INIT) begin
      cnt_q <= cnt_q + 1'b1;
      if (&cnt_q) begin
        state_q <= ST_IDLE;
        done_q  <= 1'b1;
      end
    end
  end

  // Held off while reset is asserted so the array sees no write in the reset cycle.
  assign init_busy_o = (state_q == ST_INIT) & rst_ni;
  assign init_done_o = done_q;
  assign init_addr_o = cnt_q;

endmodule

// File: rtl/ct_spsram_512x7_ctrl.sv
// Access controller for a 512x7 single-port array: power-on/invalidate clear,
// read vs. posted-write arbitration with starvation limit, and write forwarding.
module ct_spsram_512x7_ctrl
  import ct_spsram_512x7_ctrl_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = DEF_ADDR_W,
  parameter int                    DATA_WIDTH   = DEF_DATA_W,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL     = '0,
  parameter int                    MAX_WR_STALL = 4
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  inv_req,
  output logic                  init_done,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_gnt,
  output logic                  rd_data_vld,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0] wr_mask,
  output logic                  wr_rdy,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  localparam int SW = $clog2(MAX_WR_STALL + 1);
  localparam logic [SW-1:0] STALL_MAX = SW'(MAX_WR_STALL);

  function automatic logic [DATA_WIDTH-1:0] merge_fwd(
    input logic [DATA_WIDTH-1:0] q,
    input logic [DATA_WIDTH-1:0] fd,
    input logic [DATA_WIDTH-1:0] fm
  );
    return (q & ~fm) | (fd & fm);
  endfunction

  logic                  init_busy;
  logic                  init_done_w;
  logic [ADDR_WIDTH-1:0] init_addr;

  ct_spsram_init_seq #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_init_seq (
    .clk_i       (forever_cpuclk),
    .rst_ni      (cpurst_b),
    .inv_req_i   (inv_req),
    .init_busy_o (init_busy),
    .init_done_o (init_done_w),
    .init_addr_o (init_addr)
  );

  logic                  buf_vld_q, buf_vld_d;
  logic [ADDR_WIDTH-1:0] buf_addr_q;
  logic [DATA_WIDTH-1:0] buf_data_q;
  logic [DATA_WIDTH-1:0] buf_mask_q;
  logic [SW-1:0]         stall_q, stall_d;
  logic                  rd_vld_p1_q;
  logic [DATA_WIDTH-1:0] fm_p1_q;
  logic [DATA_WIDTH-1:0] fd_p1_q;

  logic force_wr;
  logic drain;
  logic wr_acc;
  logic fwd_hit;

  // Arbitration: a starved write beats the reader, otherwise reads win.
  assign force_wr = buf_vld_q & (stall_q == STALL_MAX);
  assign rd_gnt   = init_done_w & rd_req & ~force_wr;
  assign drain    = init_done_w & buf_vld_q & (force_wr | ~rd_req);
  assign wr_rdy   = init_done_w & (~buf_vld_q | drain);
  assign wr_acc   = wr_req & wr_rdy;
  assign fwd_hit  = buf_vld_q & (buf_addr_q == rd_addr);

  always_comb begin
    buf_vld_d = buf_vld_q;
    if (inv_req)     buf_vld_d = 1'b0;
    else if (wr_acc) buf_vld_d = 1'b1;
    else if (drain)  buf_vld_d = 1'b0;
  end

  always_comb begin
    stall_d = stall_q;
    if (inv_req | drain | ~buf_vld_q) stall_d = '0;
    else if (stall_q != STALL_MAX)    stall_d = stall_q + SW'(1);
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      buf_vld_q   <= 1'b0;
      stall_q     <= '0;
      rd_vld_p1_q <= 1'b0;
    end else begin
      buf_vld_q   <= buf_vld_d;
      stall_q     <= stall_d;
      rd_vld_p1_q <= rd_gnt;
    end
  end

  // Payload registers carry no reset; their valid flags above qualify them.
  always_ff @(posedge forever_cpuclk) begin
    if (wr_acc) begin
      buf_addr_q <= wr_addr;
      buf_data_q <= wr_data;
      buf_mask_q <= wr_mask;
    end
    if (rd_gnt) begin
      fm_p1_q <= fwd_hit ? buf_mask_q : '0;
      fd_p1_q <= fwd_hit ? buf_data_q : '0;
    end
  end

  // ---- stage p1: array data returns, merged with the forwarded write ----
  assign rd_data_vld = rd_vld_p1_q;
  assign rd_data     = rd_vld_p1_q ? merge_fwd(sram_q, fd_p1_q, fm_p1_q) : '0;
  assign init_done   = init_done_w;

  always_comb begin
    sram_a    = '0;
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    sram_d    = '0;
    if (init_busy) begin
      sram_a    = init_addr;
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = '0;
      sram_d    = INIT_VAL;
    end else if (drain) begin
      sram_a    = buf_addr_q;
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = ~buf_mask_q;
      sram_d    = buf_data_q;
    end else if (rd_gnt) begin
      sram_a    = rd_addr;
      sram_cen  = 1'b0;
    end
  end

endmodule
